// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way round-robin arbiter holding each grant until done, request drop or hold limit.
module rr_arbiter8 #(
    parameter int MAX_HOLD = 15,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req_i,
    input  logic       done_i,
    output logic [7:0] gnt_o,
    output logic [2:0] gnt_idx_o,
    output logic       gnt_valid_o,
    output logic       timeout_o
);
    typedef enum logic {IDLE, GRANT} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_HOLD - 1);
    state_t           state_q;
    logic [7:0]       gnt_q;
    logic [2:0]       idx_q, ptr_q, off, win;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, to_fire, rel;
    // Scan downward so the requester closest to ptr is the last one written.
    always_comb begin
        off = 3'd0;
        for (int k = 7; k >= 0; k--)
            if (req_i[ptr_q + 3'(k)]) off = 3'(k);
        win     = ptr_q + off;
        to_fire = (MAX_HOLD != 0) && (cnt_q == LAST);
        rel     = done_i || !req_i[idx_q] || to_fire;
        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= 8'h00;
            idx_q     <= 3'd0;
            ptr_q     <= 3'd0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (state_q == IDLE) begin
                if (|req_i) begin
                    state_q <= GRANT;
                    gnt_q   <= 8'h01 << win;
                    idx_q   <= win;
                    cnt_q   <= '0;
                end
            end else if (rel) begin
                state_q   <= IDLE;
                gnt_q     <= 8'h00;
                ptr_q     <= idx_q + 3'd1;
                timeout_q <= to_fire && !done_i && req_i[idx_q];
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end
    assign gnt_o       = gnt_q;
    assign gnt_idx_o   = idx_q;
    assign gnt_valid_o = (state_q == GRANT);
    assign timeout_o   = timeout_q;
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed vector table plus a hold-limit sequence for rr_arbiter8 with MAX_HOLD=4.
module tb_rr_arbiter8;
    logic       clk = 1'b0, rst_n = 1'b0, done_i = 1'b0;
    logic [7:0] req_i = 8'hFF;
    logic [7:0] gnt_o;
    logic [2:0] gnt_idx_o;
    logic       gnt_valid_o, timeout_o;
    int         checks = 0, errors = 0;

    typedef struct {
        logic       rst_n;
        logic [7:0] req;
        logic       done;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       to;
    } vec_t;
    vec_t vq[$];

    rr_arbiter8 #(.MAX_HOLD(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .done_i(done_i),
        .gnt_o(gnt_o), .gnt_idx_o(gnt_idx_o), .gnt_valid_o(gnt_valid_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [7:0] q, input logic d,
                       input logic [7:0] g, input logic [2:0] x, input logic v, input logic t);
        vec_t e;
        e.rst_n = r; e.req = q; e.done = d; e.gnt = g; e.idx = x; e.valid = v; e.to = t;
        vq.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] g, input logic [2:0] x,
                         input logic v, input logic t);
        checks++;
        if (gnt_o !== g || gnt_idx_o !== x || gnt_valid_o !== v || timeout_o !== t) begin
            errors++;
            $display("FAIL %s: got gnt=%h idx=%0d valid=%b to=%b, want gnt=%h idx=%0d valid=%b to=%b",
                     name, gnt_o, gnt_idx_o, gnt_valid_o, timeout_o, g, x, v, t);
        end
    endtask

    initial begin
        int n;
        // reset with all requests up, then first grant from ptr=0
        add(0, 8'hFF, 0, 8'h00, 3'd0, 0, 0);
        add(0, 8'hFF, 0, 8'h00, 3'd0, 0, 0);
        add(1, 8'hFF, 0, 8'h01, 3'd0, 1, 0);
        // full rotation 0..7,0 with one idle cycle per handover
        for (int i = 1; i <= 8; i++) begin
            add(1, 8'hFF, 1, 8'h00, 3'((i - 1) % 8), 0, 0);
            add(1, 8'hFF, 0, 8'(1 << (i % 8)), 3'(i % 8), 1, 0);
        end
        // wrap from 6 to 0, then skip ahead to 5
        add(1, 8'hFF, 1, 8'h00, 3'd0, 0, 0);
        add(1, 8'h40, 0, 8'h40, 3'd6, 1, 0);
        add(1, 8'h21, 1, 8'h00, 3'd6, 0, 0);
        add(1, 8'h21, 0, 8'h01, 3'd0, 1, 0);
        add(1, 8'h21, 1, 8'h00, 3'd0, 0, 0);
        add(1, 8'h21, 0, 8'h20, 3'd5, 1, 0);
        // owner drops its request; idle keeps last index
        add(1, 8'h01, 0, 8'h00, 3'd5, 0, 0);
        add(1, 8'h00, 0, 8'h00, 3'd5, 0, 0);
        // forced release after 4 cycles, then ptr=4 picks idx 4 over 3
        add(1, 8'h08, 0, 8'h08, 3'd3, 1, 0);
        add(1, 8'h08, 0, 8'h08, 3'd3, 1, 0);
        add(1, 8'h08, 0, 8'h08, 3'd3, 1, 0);
        add(1, 8'h08, 0, 8'h08, 3'd3, 1, 0);
        add(1, 8'h08, 0, 8'h00, 3'd3, 0, 1);
        add(1, 8'h18, 0, 8'h10, 3'd4, 1, 0);
        // done coincides with the hold limit: no timeout pulse
        add(1, 8'h18, 0, 8'h10, 3'd4, 1, 0);
        add(1, 8'h18, 0, 8'h10, 3'd4, 1, 0);
        add(1, 8'h18, 0, 8'h10, 3'd4, 1, 0);
        add(1, 8'h18, 1, 8'h00, 3'd4, 0, 0);
        add(1, 8'h18, 0, 8'h08, 3'd3, 1, 0);
        // reset while idx 5 owns the grant
        add(1, 8'h20, 1, 8'h00, 3'd3, 0, 0);
        add(1, 8'h20, 0, 8'h20, 3'd5, 1, 0);
        add(0, 8'h20, 0, 8'h00, 3'd0, 0, 0);
        add(1, 8'hFF, 0, 8'h01, 3'd0, 1, 0);

        for (int i = 0; i < vq.size(); i++) begin
            rst_n  = vq[i].rst_n;
            req_i  = vq[i].req;
            done_i = vq[i].done;
            step();
            check($sformatf("vec%0d", i), vq[i].gnt, vq[i].idx, vq[i].valid, vq[i].to);
        end

        // measure hold length of a sole requester under the limit
        req_i  = 8'h01;
        done_i = 1'b1;
        step();
        check("pre_hold", 8'h00, 3'd0, 0, 0);
        done_i = 1'b0;
        step();
        n = 0;
        for (int k = 0; k < 20 && gnt_valid_o; k++) begin
            n++;
            step();
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL hold_len: got %0d cycles, want 4", n);
        end
        check("to_pulse", 8'h00, 3'd0, 0, 1);
        req_i = 8'h00;
        step();
        check("to_clear", 8'h00, 3'd0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
